// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encoding and default timing constants
package game_pkg;

   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      DYING   = 2'd1,
      RESPAWN = 2'd2,
      OVER    = 2'd3
   } game_state_t;

   localparam logic [7:0] DEATH_FRAMES_DEFAULT  = 8'd60;
   localparam logic [1:0] INITIAL_LIVES_DEFAULT = 2'd3;

   // Lives saturate at zero rather than wrapping to three.
   function automatic logic [1:0] lives_dec(input logic [1:0] cur);
      return (cur == 2'd0) ? 2'd0 : cur - 2'd1;
   endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - 8-bit frame tick counter with synchronous clear
module frame_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       tick,
   output logic [7:0] count
);

   // Clear wins over tick so the count starts at zero on the entry frame.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= 8'd0;
      end else if (tick) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - player/alien/shot collision arbitration and life tracking
module collision_ctrl
   import game_pkg::*;
#(
   parameter logic [7:0] DEATH_FRAMES  = DEATH_FRAMES_DEFAULT,
   parameter logic [1:0] INITIAL_LIVES = INITIAL_LIVES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       player_dr,
   input  logic       alien_dr,
   input  logic       shot_dr,
   output logic       alien_died,
   output logic       shot_hit,
   output logic       player_died,
   output logic [1:0] lives,
   output logic       game_over
);

   game_state_t state;
   game_state_t state_nxt;
   logic [1:0]  lives_q;
   logic [1:0]  lives_nxt;
   logic [7:0]  frame_cnt;
   logic        cnt_clear;
   logic        kill_done;
   logic        hit_flag;
   logic        rst_d;
   logic        in_play;
   logic        kill_now;
   logic        hit_now;

   frame_counter u_frame_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .tick  (startOfFrame),
      .count (frame_cnt)
   );

   assign in_play = (state == PLAY);

   // Kill strobe is zero-latency so the alien block can steer it to the
   // alien drawing this very pixel; it is muted across the reset boundary.
   assign kill_now = alien_dr & shot_dr & in_play & ~kill_done & ~reset & ~rst_d;
   assign hit_now  = in_play & player_dr & alien_dr & ~shot_dr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PLAY;
         lives_q   <= INITIAL_LIVES;
         kill_done <= 1'b0;
         hit_flag  <= 1'b0;
         rst_d     <= 1'b1;
      end else begin
         state     <= state_nxt;
         lives_q   <= lives_nxt;
         kill_done <= kill_now | (kill_done & ~startOfFrame);
         hit_flag  <= ~startOfFrame & (hit_flag | hit_now);
         rst_d     <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      lives_nxt = lives_q;
      cnt_clear = 1'b0;
      if (startOfFrame) begin
         case (state)
            PLAY: begin
               if (hit_flag || hit_now) begin
                  state_nxt = DYING;
                  lives_nxt = lives_dec(lives_q);
                  cnt_clear = 1'b1;
               end
            end
            DYING: begin
               if (frame_cnt == DEATH_FRAMES - 8'd1) begin
                  state_nxt = (lives_q == 2'd0) ? OVER : RESPAWN;
               end
            end
            RESPAWN: state_nxt = PLAY;
            OVER:    state_nxt = OVER;
            default: state_nxt = PLAY;
         endcase
      end
   end

   always_comb begin
      alien_died  = kill_now;
      shot_hit    = kill_now;
      player_died = ~reset & (state != PLAY);
      game_over   = ~reset & (state == OVER);
      lives       = lives_q;
   end

endmodule

// File: tb/tb_collision_ctrl.sv
// tb/tb_collision_ctrl.sv - randomized and directed bench against a frame-level life model
module tb_collision_ctrl;

   localparam int DF = 60;
   localparam int INIT_LIVES = 3;

   logic       clk;
   logic       reset;
   logic       startOfFrame;
   logic       player_dr;
   logic       alien_dr;
   logic       shot_dr;
   logic       alien_died;
   logic       shot_hit;
   logic       player_died;
   logic [1:0] lives;
   logic       game_over;

   int n_vec;
   int n_bad;

   // Reference model: lives left, sofs still to wait before play resumes,
   // game-over flag, catch seen this frame, kill used this frame.
   int m_lives;
   int m_frozen;
   bit m_over;
   bit m_caught;
   bit m_killed;
   bit m_rst_prev;

   collision_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .player_dr    (player_dr),
      .alien_dr     (alien_dr),
      .shot_dr      (shot_dr),
      .alien_died   (alien_died),
      .shot_hit     (shot_hit),
      .player_died  (player_died),
      .lives        (lives),
      .game_over    (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lives    = INIT_LIVES;
      m_frozen   = 0;
      m_over     = 1'b0;
      m_caught   = 1'b0;
      m_killed   = 1'b0;
      m_rst_prev = 1'b1;
   endtask

   task automatic step(input bit p, input bit a, input bit s, input bit sof, input bit rst);
      bit playing;
      bit kill;
      bit catch_now;
      @(negedge clk);
      player_dr    = p;
      alien_dr     = a;
      shot_dr      = s;
      startOfFrame = sof;
      reset        = rst;
      #1;
      playing   = !m_over && (m_frozen == 0);
      kill      = !rst && !m_rst_prev && a && s && playing && !m_killed;
      catch_now = playing && p && a && !s;
      check_val("alien_died", alien_died, kill);
      check_val("shot_hit", shot_hit, kill);
      check_val("player_died", player_died, rst ? 0 : !playing);
      check_val("game_over", game_over, rst ? 0 : m_over);
      check_val("lives", lives, m_lives);
      if (rst) begin
         model_reset();
      end else begin
         m_rst_prev = 1'b0;
         if (sof) begin
            if (playing && (m_caught || catch_now)) begin
               if (m_lives > 0) m_lives--;
               m_frozen = DF + 1;
            end else if (m_frozen > 0) begin
               m_frozen--;
               if (m_frozen == 1 && m_lives == 0) begin
                  m_over   = 1'b1;
                  m_frozen = 0;
               end
            end
            m_caught = 1'b0;
            m_killed = kill;
         end else begin
            m_caught = m_caught || catch_now;
            m_killed = m_killed || kill;
         end
      end
   endtask

   task automatic frames(input int n);
      for (int f = 0; f < n; f++) begin
         step(0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      startOfFrame = 1'b0;
      player_dr = 1'b0;
      alien_dr = 1'b0;
      shot_dr = 1'b0;
      @(posedge clk);
      model_reset();

      // Reset cycle and the cycle after, with collision inputs active.
      step(1, 1, 1, 0, 1);
      step(0, 1, 1, 0, 0);
      check_val("post_reset_kill", alien_died, 0);
      check_val("post_reset_lives", lives, INIT_LIVES);
      frames(1);

      // One kill per frame.
      step(0, 0, 0, 1, 0);
      step(0, 1, 1, 0, 0);
      check_val("kill_first", alien_died, 1);
      step(0, 1, 1, 0, 0);
      check_val("kill_second", alien_died, 0);
      step(0, 1, 1, 0, 0);
      check_val("kill_third", shot_hit, 0);
      frames(1);
      check_val("kill_lives", lives, 3);

      // Triple overlap: kill wins, player survives.
      step(1, 1, 1, 0, 0);
      check_val("triple_kill", alien_died, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      check_val("triple_alive", player_died, 0);
      check_val("triple_lives", lives, 3);

      // Catch mid-frame, full death sequence.
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      check_val("catch_dead", player_died, 1);
      check_val("catch_lives", lives, 2);
      step(1, 1, 0, 0, 0);
      frames(DF - 1);
      check_val("dying_held", player_died, 1);
      frames(1);
      check_val("respawn_held", player_died, 1);
      frames(1);
      check_val("back_to_play", player_died, 0);
      check_val("back_lives", lives, 2);

      // Catch in the sof cycle itself, then reset at frame_cnt 20.
      step(1, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      check_val("sof_catch", player_died, 1);
      frames(20);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      check_val("rst_dying_pd", player_died, 0);
      check_val("rst_dying_lives", lives, 3);

      // Three catches to game over.
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, 1, 0);
         frames(DF + 1);
      end
      check_val("over_flag", game_over, 1);
      check_val("over_lives", lives, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      check_val("over_nokill", alien_died, 0);
      frames(2);
      check_val("over_stays", game_over, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      check_val("over_reset", game_over, 0);
      check_val("over_reset_lives", lives, 3);

      // Randomized traffic.
      for (int i = 0; i < 8000; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 699) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/collision_ctrl.md
COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 Parameter DEATH_FRAMES, default 8'd60: frames the player stays frozen after being caught.
REQ-002 Parameter INITIAL_LIVES, default 2'd3: lives loaded at reset.
REQ-003 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port startOfFrame, input, 1: one-cycle pulse at the start of each video frame.
REQ-006 Port player_dr, input, 1: player drawing request for the current pixel.
REQ-007 Port alien_dr, input, 1: merged alien drawing request from the alien block.
REQ-008 Port shot_dr, input, 1: shot drawing request for the current pixel.
REQ-009 Port alien_died, output, 1: kill strobe, valid in the same cycle as the alien pixel.
REQ-010 Port shot_hit, output, 1: one-cycle pulse to retire the shot; equals alien_died.
REQ-011 Port player_died, output, 1: level; high while the player is dead or out of lives.
REQ-012 Port lives, output, 2: remaining lives.
REQ-013 Port game_over, output, 1: level; high in state OVER.

Function
REQ-014 States: PLAY, DYING, RESPAWN, OVER.
REQ-015 alien_died is combinational: alien_dr & shot_dr & (state==PLAY) & ~kill_done. Latency 0 is required because the alien block steers the strobe to whichever alien is drawing that pixel.
REQ-016 kill_done is set in the cycle alien_died is high and cleared on startOfFrame. Result: at most one kill per frame.
REQ-017 hit_flag is set in PLAY when player_dr & alien_dr are both high and shot_dr is low. It is cleared on startOfFrame.
REQ-018 If player_dr, alien_dr and shot_dr are all high in the same cycle, the alien kill wins and hit_flag is not set.
REQ-019 PLAY->DYING occurs on startOfFrame when (hit_flag | current-cycle hit) is true. In that same cycle, lives decrements by 1.
REQ-020 In DYING, frame_cnt (8-bit) loads 0 on entry and increments on each startOfFrame. DYING->RESPAWN occurs on the startOfFrame where frame_cnt==DEATH_FRAMES-1.
REQ-021 RESPAWN lasts exactly one frame; RESPAWN->PLAY occurs on the next startOfFrame. If lives==0 at the RESPAWN entry, the transition is DYING->OVER instead.
REQ-022 player_died is high in DYING, RESPAWN and OVER, and low in PLAY.
REQ-023 OVER is absorbing; only reset leaves it.
REQ-024 lives never wraps: a decrement at 0 is suppressed.
REQ-025 Collisions that occur outside PLAY are ignored and set no flag.
REQ-026 State changes only on startOfFrame cycles; input activity between frames only updates the flags.

Reset
REQ-027 On reset: state=PLAY, lives=INITIAL_LIVES, frame_cnt=0, hit_flag=0, kill_done=0.
REQ-028 In the reset cycle and the cycle after: alien_died=0, shot_hit=0, player_died=0, game_over=0.
REQ-029 Reset asserted mid-DYING or in OVER returns the block to PLAY on the next edge, with no residual flags.

Structure
REQ-030 The state enum (PLAY, DYING, RESPAWN, OVER) lives in shared package game_pkg, together with the default values for DEATH_FRAMES and INITIAL_LIVES.
REQ-031 The frame counter is implemented as sub-module frame_counter (clk, reset, clear, tick=startOfFrame, count[7:0]).
REQ-032 The block is single-clock and has no latches.

Verification
REQ-033 Stimulus: PLAY, alien_dr=shot_dr=1 for 3 cycles in one frame. Required: alien_died=1 in the first cycle only; shot_hit matches; lives stays 3.
REQ-034 Stimulus: player_dr=alien_dr=1 mid-frame, then startOfFrame. Required: state=DYING, lives=2, player_died=1; after 60 further startOfFrame pulses, RESPAWN; one frame later, PLAY.
REQ-035 Stimulus: player_dr=alien_dr=shot_dr=1 in the same cycle. Required: alien_died=1; at the next startOfFrame the state stays PLAY and lives=3.
REQ-036 Stimulus: three player catches, each followed by the full death sequence. Required: after the third, lives=0 and game_over=1; a further collision changes nothing.
REQ-037 Stimulus: reset asserted for 1 cycle during DYING with frame_cnt=20. Required: next cycle state=PLAY, lives=3, player_died=0.
REQ-038 Stimulus: collision in the same cycle as startOfFrame. Required: DYING entered in that same cycle.
